// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        PRIO0  = 2'd0,
        FORCE1 = 2'd1,
        LOCK1  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic        we;
        logic        u;
    } mem_req_t;

    localparam logic [3:0]  BMASK_B      = 4'b0001;
    localparam logic [3:0]  BMASK_H      = 4'b0011;
    localparam logic [3:0]  BMASK_W      = 4'b1111;
    localparam logic [31:0] MEM_TOP_ADDR = 32'h7FF;

endpackage

// File: rtl/dmem_arb_resp.sv
// One-cycle response register: acknowledges every grant, returns load data or 0 for stores.
module dmem_arb_resp (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_gnt,
    input  logic        i_we,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rvalid,
    output logic [31:0] o_rdata
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
        end else begin
            o_rvalid <= i_gnt;
            o_rdata  <= (i_gnt && !i_we) ? i_mem_rdata : '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 (core) by default,
// with a starvation guard and a bus-lock mode for port 1 (loader).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_bmask,
    input  logic        i_m0_we,
    input  logic        i_m0_u,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_bmask,
    input  logic        i_m1_we,
    input  logic        i_m1_u,
    input  logic        i_m1_lock,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    output logic        o_mem_u,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);

    arb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    mem_req_t         req0;
    mem_req_t         req1;
    mem_req_t         mem_req;
    logic             gnt0;
    logic             gnt1;
    logic             m1_denied;

    assign req0 = {i_m0_addr, i_m0_wdata, i_m0_bmask, i_m0_we, i_m0_u};
    assign req1 = {i_m1_addr, i_m1_wdata, i_m1_bmask, i_m1_we, i_m1_u};

    // Grants and memory lines are gated by i_reset so they sit at reset values while it is held.
    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_reset) begin
            case (state)
                PRIO0: begin
                    gnt0 = i_m0_req;
                    gnt1 = i_m1_req && !i_m0_req;
                end
                FORCE1: begin
                    gnt1 = i_m1_req;
                    gnt0 = i_m0_req && !i_m1_req;
                end
                LOCK1:   gnt1 = i_m1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req = '0;
        if (i_reset) begin
            mem_req = gnt1 ? req1 : req0;
            if (!gnt0 && !gnt1) begin
                mem_req.we    = 1'b0;
                mem_req.bmask = '0;
            end
        end
    end

    assign m1_denied = i_m1_req && !gnt1;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= PRIO0;
            wait_cnt <= '0;
        end else begin
            if (gnt1 || !i_m1_req)
                wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;

            if (gnt1 && i_m1_lock) begin
                state <= LOCK1;
            end else begin
                case (state)
                    PRIO0:   if (m1_denied && wait_cnt == WAIT_LAST) state <= FORCE1;
                    FORCE1:  if (gnt1) state <= PRIO0;
                    LOCK1:   if (!i_m1_lock && (gnt1 || !i_m1_req)) state <= PRIO0;
                    default: state <= PRIO0;
                endcase
            end
        end
    end

    assign o_m0_gnt    = gnt0;
    assign o_m1_gnt    = gnt1;
    assign o_mem_addr  = mem_req.addr;
    assign o_mem_wdata = mem_req.wdata;
    assign o_mem_bmask = mem_req.bmask;
    assign o_mem_wren  = mem_req.we;
    assign o_mem_u     = mem_req.u;

    dmem_arb_resp u_resp0 (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_gnt       (gnt0),
        .i_we        (i_m0_we),
        .i_mem_rdata (i_mem_rdata),
        .o_rvalid    (o_m0_rvalid),
        .o_rdata     (o_m0_rdata)
    );

    dmem_arb_resp u_resp1 (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_gnt       (gnt1),
        .i_we        (i_m1_we),
        .i_mem_rdata (i_mem_rdata),
        .o_rvalid    (o_m1_rvalid),
        .o_rdata     (o_m1_rdata)
    );

endmodule
